flatten_reader: RTL and testbench

Sequential read-out stage for the flattened feature buffer. Once `flatten_buffer` asserts full, this block walks its 225-entry parallel array from index 0 to 224 and emits one signed 22-bit element per accepted transfer on a valid/ready stream. The stream feeds the fully-connected layer. The block fires exactly once per full event and re-arms only after the buffer has been cleared.

---
 rtl/npu_pkg.sv | 17 +
 rtl/flatten_reader_if.sv | 30 +++
 rtl/flatten_reader.sv | 98 +++++++++
 tb/tb_flatten_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: activation word, flatten length
// and the flatten reader state encoding.
package npu_pkg;

  localparam int DATA_W   = 22;
  localparam int FLAT_LEN = 225;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STREAM,
    RD_DONE,
    RD_WAIT_CLEAR
  } flat_rd_state_t;

endpackage

// File: rtl/flatten_reader_if.sv
// Valid/ready element stream from the flatten reader
// into the fully-connected layer.
interface flatten_reader_if #(
  parameter int DATA_W = npu_pkg::DATA_W,
  parameter int IDX_W  = 8
);

  logic                     o_data_valid;
  logic signed [DATA_W-1:0] o_data_out;
  logic [IDX_W-1:0]         o_index;
  logic                     o_last;
  logic                     i_ready;

  modport master (
    output o_data_valid,
    output o_data_out,
    output o_index,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data_valid,
    input  o_data_out,
    input  o_index,
    input  o_last,
    output i_ready
  );

endinterface

// File: rtl/flatten_reader.sv
// Walks the full flatten buffer once per full event and
// streams one element per accepted transfer.
module flatten_reader
  import npu_pkg::*;
#(
  parameter int BUFFER_SIZE = FLAT_LEN,
  parameter int DATA_W      = npu_pkg::DATA_W,
  parameter int IDX_W       = $clog2(BUFFER_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_buffer_full,
  input  logic signed [DATA_W-1:0] i_flattened_data [BUFFER_SIZE],
  flatten_reader_if.master         strm,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(BUFFER_SIZE - 1);

  flat_rd_state_t           state_q, state_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic                     last_q, last_d;
  logic [IDX_W-1:0]         nxt_idx;

  assign nxt_idx = index_q + 1'b1;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    unique case (state_q)
      RD_IDLE: begin
        if (i_buffer_full) begin
          state_d = RD_STREAM;
          valid_d = 1'b1;
          data_d  = i_flattened_data[0];
          index_d = '0;
          last_d  = (BUFFER_SIZE == 1);
        end
      end
      RD_STREAM: begin
        // a dropped full flag is ignored; the frame always completes
        if (valid_q && strm.i_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = RD_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            data_d  = i_flattened_data[nxt_idx];
            index_d = nxt_idx;
            last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end
      RD_DONE: begin
        state_d = RD_WAIT_CLEAR;
      end
      RD_WAIT_CLEAR: begin
        if (!i_buffer_full) begin
          state_d = RD_IDLE;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign strm.o_data_valid = valid_q;
  assign strm.o_data_out   = data_q;
  assign strm.o_index      = index_q;
  assign strm.o_last       = last_q;
  assign o_busy            = (state_q == RD_STREAM);
  assign o_done            = (state_q == RD_DONE);

endmodule

// File: tb/tb_flatten_reader.sv
// Scoreboard bench for flatten_reader: frame table,
// backpressure, one-shot, and mid-frame reset.
module tb_flatten_reader;
  import npu_pkg::*;

  localparam int N = FLAT_LEN;

  logic clk = 1'b0;
  logic rst;
  logic full;
  logic busy;
  logic done;
  act_t mem [N];

  flatten_reader_if #(
    .DATA_W(DATA_W),
    .IDX_W (8)
  ) strm ();

  flatten_reader dut (
    .clk             (clk),
    .rst             (rst),
    .i_buffer_full   (full),
    .i_flattened_data(mem),
    .strm            (strm.master),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    act_t data;
    int   idx;
  } exp_t;

  typedef struct {
    int pat;
    int rmode;
    int exp_hs;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   n_chk;
  int   n_fail;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic act_t pat_val(int pat, int i);
    case (pat)
      0:       return act_t'(i - 112);
      1:       return (i % 2 == 0) ? act_t'(-2097152)
                                   : act_t'(2097151);
      default: return act_t'($urandom);
    endcase
  endfunction

  function automatic logic rdy(int rmode, int c);
    case (rmode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return (c >= 10);
    endcase
  endfunction

  task automatic drop_full();
    full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(
    input  int pat,
    input  int rmode,
    output int hs
  );
    int   c;
    logic ev;
    logic done_exp;
    logic finished;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      mem[i] = pat_val(pat, i);
      exp_q.push_back('{mem[i], i});
    end
    full         = 1'b1;
    strm.i_ready = 1'b0;
    hs           = 0;
    c            = 0;
    done_exp     = 1'b0;
    finished     = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2000; k++) begin
      ev = (exp_q.size() != 0);
      chk("valid", strm.o_data_valid, ev);
      chk("busy", busy, ev);
      chk("done", done, done_exp);
      if (done_exp) begin
        finished = 1'b1;
        break;
      end
      strm.i_ready = rdy(rmode, c);
      if (ev) begin
        chk("data", strm.o_data_out, exp_q[0].data);
        chk("index", strm.o_index, exp_q[0].idx);
        chk("last", strm.o_last,
            exp_q[0].idx == N - 1);
        if (strm.i_ready) begin
          void'(exp_q.pop_front());
          hs++;
          if (exp_q.size() == 0) done_exp = 1'b1;
        end
      end
      c++;
      @(negedge clk);
    end
    chk("frame_timeout", finished, 1'b1);
    strm.i_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("valid_after", strm.o_data_valid, 1'b0);
  endtask

  initial begin
    int hs;
    int bad;
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{0, 0, N};
    vecs[1] = '{0, 1, N};
    vecs[2] = '{1, 0, N};
    vecs[3] = '{2, 2, N};
    vecs[4] = '{1, 1, N};

    rst          = 1'b1;
    full         = 1'b0;
    strm.i_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", strm.o_data_valid, 1'b0);
    chk("rst_data", strm.o_data_out, 0);
    chk("rst_index", strm.o_index, 0);
    chk("rst_last", strm.o_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].pat, vecs[v].rmode, hs);
      chk("handshakes", hs, vecs[v].exp_hs);
      drop_full();
    end

    run_frame(0, 0, hs);
    chk("oneshot_hs", hs, N);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (strm.o_data_valid || busy || done) bad++;
    end
    chk("oneshot_quiet", bad, 0);
    drop_full();
    run_frame(2, 0, hs);
    chk("rearm_hs", hs, N);
    drop_full();

    for (int i = 0; i < N; i++) mem[i] = pat_val(0, i);
    full         = 1'b1;
    strm.i_ready = 1'b1;
    @(negedge clk);
    repeat (100) @(negedge clk);
    chk("pre_rst_index", strm.o_index, 100);
    chk("pre_rst_data", strm.o_data_out,
        pat_val(0, 100));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", strm.o_data_valid, 1'b0);
    chk("mid_rst_data", strm.o_data_out, 0);
    chk("mid_rst_index", strm.o_index, 0);
    chk("mid_rst_last", strm.o_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    run_frame(0, 0, hs);
    chk("restart_hs", hs, N);
    drop_full();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
